baby_store_ctrl: RTL
====================

// Module: baby_store_ctrl
// PURPOSE
//   Parametrised main store for the Manchester Baby core: DEPTH x DATA_W word
//   array with a CPU port and an arbitrated host port for program load/readback.
//   Includes a hardware clear sequencer that zeroes the store.
//   Sits between manchester_baby and the SPI host interface in user_proj_example.
//   Supersedes the fixed ram_5x32.
// PARAMETERS
//   ADDR_W          5   address width; DEPTH = 2**ADDR_W words
//   DATA_W         32   word width
//   CLEAR_ON_RESET  1   1: enter CLEAR after reset release; 0: enter RUN directly
// PORTS
//   clk_i        in   1       single clock; all state updates on rising edge
//   reset_ni     in   1       asynchronous, active-low reset
//   cpu_addr_i   in   ADDR_W  CPU word address
//   cpu_data_i   in   DATA_W  CPU write data
//   cpu_we_i     in   1       CPU write enable
//   cpu_data_o   out  DATA_W  CPU read data: mem[cpu_addr_i], combinational
//   cpu_hold_o   out  1       CPU must stall; CPU writes are dropped while high
//   host_req_i   in   1       host access request (level)
//   host_we_i    in   1       host access is a write
//   host_addr_i  in   ADDR_W  host word address
//   host_data_i  in   DATA_W  host write data
//   host_ack_o   out  1       one-cycle access-complete pulse
//   host_data_o  out  DATA_W  host read data, valid while host_ack_o is high
//   clear_i      in   1       request a store clear
//   busy_o       out  1       clear sequence in progress
// BEHAVIOUR
//   - Reset (reset_ni=0): state=CLEAR if CLEAR_ON_RESET else RUN.
//     - Clear counter=0; host_ack_o=0; host_data_o=0.
//     - cpu_hold_o=busy_o=CLEAR_ON_RESET.
//     - The memory array is not reset. Its contents are undefined until cleared or written.
//   - States: CLEAR, RUN, HOST, ACK_WAIT.
//   - CLEAR:
//     - Writes 0 to mem[cnt] each cycle, cnt = 0..DEPTH-1.
//     - busy_o=1 and cpu_hold_o=1; CPU writes are ignored.
//     - When cnt==DEPTH-1: cnt wraps to 0 and the state goes to RUN.
//     - Duration is exactly DEPTH cycles.
//     - clear_i and host_req_i are ignored in this state (the request stays pending).
//   - RUN:
//     - If cpu_we_i: mem[cpu_addr_i] <= cpu_data_i.
//     - Priority at each edge: clear_i -> CLEAR; else host_req_i -> HOST; else stay in RUN.
//     - A CPU write in the same cycle as the transition still commits (hold is not yet high).
//   - HOST (exactly one cycle):
//     - cpu_hold_o=1; the CPU write is dropped.
//     - At the closing edge: if host_we_i, mem[host_addr_i] <= host_data_i; else host_data_o <= mem[host_addr_i].
//     - host_ack_o <= 1; next state is ACK_WAIT.
//   - ACK_WAIT:
//     - host_ack_o is high for the first cycle only, then 0.
//     - cpu_hold_o=0 and CPU writes are permitted.
//     - Return to RUN once host_req_i is sampled low.
//     - A req held high does not retrigger an access.
//     - clear_i in ACK_WAIT -> CLEAR.
//   - Latency: req sampled high at edge k (in RUN) -> HOST during cycle k..k+1.
//     - host_ack_o is high in cycle k+1..k+2.
//     - A host write is visible on cpu_data_o from edge k+1.
//   - Read-during-write on the CPU port: cpu_data_o shows the old word until the write edge.
//   - host_data_o holds its last read value until the next host read.
//   - Reset mid-CLEAR or mid-HOST: the state returns to the reset state immediately.
//     - A partial clear is not resumed. A host write at the asserting edge is not guaranteed.
//   - Addresses are full-range (no out-of-range case). cnt is ADDR_W bits and wraps naturally.
// TESTING
//   1. Reset release, CLEAR_ON_RESET=1, ADDR_W=5:
//      - busy_o high for exactly 32 cycles; then read all addresses via the CPU port -> all 0.
//   2. Host write:
//      - Host writes 0xDEADBEEF to addr 7 -> host_ack_o pulses once.
//      - cpu_addr_i=7 -> cpu_data_o=0xDEADBEEF.
//      - Hold req 5 more cycles -> no second ack.
//   3. CPU write then host read:
//      - CPU writes 0x0000_1234 to addr 31.
//      - Host reads addr 31 -> host_data_o=0x0000_1234 with ack.
//   4. Collisions:
//      - In RUN, assert clear_i and host_req_i together -> CLEAR runs first.
//      - The host ack arrives DEPTH+2 cycles later.
//   5. Hold/drop:
//      - CPU we to addr 3 (0xAAAA) during a HOST cycle -> the write is dropped; addr 3 keeps its old value.
//   6. Mid-clear reset:
//      - Pulse reset_ni low at clear cycle 10 -> the clear restarts from addr 0.
//      - busy_o is high for 32 further cycles.
//      - Repeat with ADDR_W=3, DATA_W=8 -> busy_o is high for 8 cycles.

Source files
------------

// File: rtl/baby_store_ctrl.sv
// Manchester Baby main store: CPU port, arbitrated host port and
// a hardware clear sequencer that zeroes every word.
module baby_store_ctrl #(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_we_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_hold_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_data_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_data_o,
  input  logic              clear_i,
  output logic              busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_HOST,
    S_ACK
  } state_e;

  localparam state_e RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                ack_q;
  logic [DATA_W-1:0]   hdata_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // One write port: the current state picks its owner.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cpu_addr_i;
    mem_wdata = cpu_data_i;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
      end
      S_HOST: begin
        mem_we    = host_we_i;
        mem_waddr = host_addr_i;
        mem_wdata = host_data_i;
      end
      default: mem_we = cpu_we_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      hdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) state_q <= S_RUN;
        end
        S_RUN: begin
          if (clear_i)         state_q <= S_CLEAR;
          else if (host_req_i) state_q <= S_HOST;
        end
        S_HOST: begin
          if (!host_we_i) hdata_q <= mem_q[host_addr_i];
          ack_q   <= 1'b1;
          state_q <= S_ACK;
        end
        S_ACK: begin
          if (clear_i)          state_q <= S_CLEAR;
          else if (!host_req_i) state_q <= S_RUN;
        end
        default: state_q <= RST_STATE;
      endcase
    end
  end

  assign cpu_data_o  = mem_q[cpu_addr_i];
  assign busy_o      = (state_q == S_CLEAR);
  assign cpu_hold_o  = (state_q == S_CLEAR) || (state_q == S_HOST);
  assign host_ack_o  = ack_q;
  assign host_data_o = hdata_q;

endmodule
